// File: rtl/mul_div_unit_pkg.sv
// Shared types and opcode-decoding helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } mdu_fun_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   function automatic logic is_div(input mdu_fun_t fun);
      return fun[2];
   endfunction

   function automatic logic op1_signed(input mdu_fun_t fun);
      return (fun == MUL) || (fun == MULH) || (fun == MULHSU) || (fun == DIV) || (fun == REM);
   endfunction

   function automatic logic op2_signed(input mdu_fun_t fun);
      return (fun == MUL) || (fun == MULH) || (fun == DIV) || (fun == REM);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response handshake bundle between the execute stage and the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic [2:0]       mdu_fun;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             div_zero;

   modport master (
      output in_valid, op1, op2, mdu_fun, out_ready,
      input  in_ready, out_valid, Result, div_zero
   );

   modport slave (
      input  in_valid, op1, op2, mdu_fun, out_ready,
      output in_ready, out_valid, Result, div_zero
   );
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate: magnitude of a signed operand, or sign restore of a result.
module mdu_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] val_o
);
   always_comb begin
      val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;
   end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply (shift-add) / restoring divide with magnitude + sign fix-up.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         CLK,
   input  logic         RST_N,
   mul_div_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   mdu_state_t           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     b_q, b_d;
   mdu_fun_t             fun_q, fun_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 div_zero_q, div_zero_d;

   mdu_fun_t             fun_in;
   logic                 s1, s2;
   logic [WIDTH-1:0]     mag1, mag2;
   logic                 div_by_zero, div_ovf;
   logic [WIDTH:0]       mul_sum, trial;
   logic [2*WIDTH-1:0]   step;
   logic [2*WIDTH-1:0]   fix_in, fix_out;
   logic                 fix_neg;
   mdu_fun_t             fix_fun;
   logic [WIDTH-1:0]     fixed_res;

   always_comb begin
      fun_in      = mdu_fun_t'(bus.mdu_fun);
      s1          = op1_signed(fun_in) & bus.op1[WIDTH-1];
      s2          = op2_signed(fun_in) & bus.op2[WIDTH-1];
      div_by_zero = is_div(fun_in) && (bus.op2 == '0);
      div_ovf     = is_div(fun_in) && op1_signed(fun_in) && (bus.op1 == MIN_NEG) && (bus.op2 == '1);
   end

   mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_op1 (.val_i(bus.op1), .neg_i(s1), .val_o(mag1));
   mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_op2 (.val_i(bus.op2), .neg_i(s2), .val_o(mag2));

   // acc holds {partial product, multiplier} for multiply, {remainder, quotient} for divide
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      trial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
      if (is_div(fun_q)) begin
         step = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                             : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         step = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   // Divide results are zero-extended so one 2*WIDTH negator serves every op
   always_comb begin
      fix_fun = fun_q;
      fix_neg = neg_q;
      if (!is_div(fun_q))
         fix_in = step;
      else if ((fun_q == REM) || (fun_q == REMU))
         fix_in = {{WIDTH{1'b0}}, step[2*WIDTH-1:WIDTH]};
      else
         fix_in = {{WIDTH{1'b0}}, step[WIDTH-1:0]};
`ifdef MDU_FAST_MUL_EN
      if (state_q == IDLE) begin
         fix_fun = fun_in;
         fix_neg = s1 ^ s2;
         fix_in  = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
      end
`endif
   end

   mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_res (.val_i(fix_in), .neg_i(fix_neg), .val_o(fix_out));

   always_comb begin
      if ((fix_fun == MUL) || is_div(fix_fun))
         fixed_res = fix_out[WIDTH-1:0];
      else
         fixed_res = fix_out[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      b_d        = b_q;
      fun_d      = fun_q;
      neg_d      = neg_q;
      result_d   = result_q;
      div_zero_d = div_zero_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               fun_d = fun_in;
               cnt_d = '0;
               neg_d = ((fun_in == REM) || (fun_in == REMU)) ? s1 : (s1 ^ s2);
               b_d   = is_div(fun_in) ? mag2 : mag1;
               acc_d = {{WIDTH{1'b0}}, (is_div(fun_in) ? mag1 : mag2)};
               if (div_by_zero) begin
                  result_d   = ((fun_in == DIV) || (fun_in == DIVU)) ? '1 : bus.op1;
                  div_zero_d = 1'b1;
                  state_d    = DONE;
               end else if (div_ovf) begin
                  result_d   = (fun_in == DIV) ? bus.op1 : '0;
                  div_zero_d = 1'b0;
                  state_d    = DONE;
`ifdef MDU_FAST_MUL_EN
               end else if (!is_div(fun_in)) begin
                  result_d   = fixed_res;
                  div_zero_d = 1'b0;
                  state_d    = DONE;
`endif
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            acc_d = step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               result_d   = fixed_res;
               div_zero_d = 1'b0;
               cnt_d      = '0;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         b_q        <= '0;
         fun_q      <= MUL;
         neg_q      <= 1'b0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         b_q        <= b_d;
         fun_q      <= fun_d;
         neg_q      <= neg_d;
         result_q   <= result_d;
         div_zero_q <= div_zero_d;
      end
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.Result    = result_q;
      bus.div_zero  = div_zero_q;
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32); honours MDU_FAST_MUL_EN for multiply latency.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   mul_div_unit_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic issue(input mdu_fun_t fun, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.mdu_fun  = fun;
      bus.op1      = a;
      bus.op2      = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Latency counts the accept edge as 1
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_eq({tag, "_handshake"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
   endtask

   task automatic run_op(input string tag, input mdu_fun_t fun, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic exp_dz, input int exp_lat);
      int lat;
      issue(fun, a, b);
      wait_valid(lat);
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_res"}, 64'(bus.Result), 64'(exp_res));
      check_eq({tag, "_dz"}, 64'(bus.div_zero), 64'(exp_dz));
      take(tag);
      check_eq({tag, "_hold_idle"}, 64'(bus.Result), 64'(exp_res));
   endtask

   initial begin
      int lat;
      n_checks      = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op1       = '0;
      bus.op2       = '0;
      bus.mdu_fun   = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_state", {30'd0, bus.in_ready, bus.out_valid, bus.div_zero, bus.Result},
               {30'd0, 1'b1, 1'b0, 1'b0, 32'd0});
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul_7_m3",     MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, MUL_LAT);
      run_op("mul_lo_wrap",  MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, MUL_LAT);
      run_op("mulh_min",     MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, MUL_LAT);
      run_op("mulhu_ones",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT);
      run_op("mulhsu_ones",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MUL_LAT);
      run_op("div_m7_2",     DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, DIV_LAT);
      run_op("rem_m7_2",     REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, DIV_LAT);
      run_op("div_7_m2",     DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, DIV_LAT);
      run_op("rem_7_m2",     REM,    32'd7,        32'hFFFF_FFFE, 32'd1,        1'b0, DIV_LAT);
      run_op("divu_100_7",   DIVU,   32'd100,      32'd7,        32'd14,       1'b0, DIV_LAT);
      run_op("remu_100_7",   REMU,   32'd100,      32'd7,        32'd2,        1'b0, DIV_LAT);
      run_op("div_5_0",      DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1, 1);
      run_op("rem_5_0",      REM,    32'd5,        32'd0,        32'd5,        1'b1, 1);
      run_op("divu_5_0",     DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1, 1);
      run_op("div_ovf",      DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
      run_op("rem_ovf",      REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b0, 1);

      // Backpressure with ignored in_valid pulses while DONE
      issue(DIVU, 32'd100, 32'd7);
      wait_valid(lat);
      check_eq("bp_lat", 64'(lat), 64'(DIV_LAT));
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = i[0];
         bus.mdu_fun  = MUL;
         bus.op1      = 32'd3;
         bus.op2      = 32'd3;
         @(posedge clk);
         #1;
         check_eq("bp_hold", {29'd0, bus.out_valid, bus.in_ready, bus.div_zero, bus.Result},
                  {29'd0, 1'b1, 1'b0, 1'b0, 32'd14});
      end
      bus.in_valid = 1'b0;
      take("bp");
      repeat (3) @(posedge clk);
      #1;
      check_eq("bp_not_latched", 64'(bus.out_valid), 64'd0);

      // Reset during BUSY aborts the operation
      issue(DIVU, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_busy", {30'd0, bus.in_ready, bus.out_valid, bus.div_zero, bus.Result},
               {30'd0, 1'b1, 1'b0, 1'b0, 32'd0});
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check_eq("rst_no_result", 64'(bus.out_valid), 64'd0);
      run_op("after_rst_mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, MUL_LAT);
      run_op("dz_clears",     DIV, 32'd100, 32'd7, 32'd14, 1'b0, DIV_LAT);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
